// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HOLD
  } fetch_state_e;

  // Instructions are word aligned, so redirect targets drop their low two bits.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Connection bundle between the fetch controller and its one-entry skid buffer.
interface fetch_if;

  logic        load;
  logic        clear;
  logic [31:0] load_instr;
  logic [31:0] load_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        vld;

  modport master (
    output load, clear, load_instr, load_pc,
    input  instr, pc, vld
  );

  modport slave (
    input  load, clear, load_instr, load_pc,
    output instr, pc, vld
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register; clear wins over load.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset_n,
  fetch_if.slave  skid
);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      skid.instr <= FETCH_NOP;
      skid.pc    <= 32'h0;
      skid.vld   <= 1'b0;
    end else if (skid.clear) begin
      skid.instr <= FETCH_NOP;
      skid.pc    <= 32'h0;
      skid.vld   <= 1'b0;
    end else if (skid.load) begin
      skid.instr <= skid.load_instr;
      skid.pc    <= skid.load_pc;
      skid.vld   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, one-cycle imem interface, skid buffer and registered IF/ID.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic        o_if_vld
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch,
  output logic [31:0] o_perf_redirect
`endif
);

  fetch_state_e state, state_nx;

  logic [31:0] pc_f, pc_nx;
  logic [31:0] inf_pc, inf_pc_nx;
  logic        inf_vld, inf_vld_nx;
  logic        req;
  logic        flush;
  logic        ifid_load;
  logic [31:0] ifid_instr_d, ifid_pc_d, ifid_pc4_d;
  logic        ifid_vld_d;

  fetch_if skid ();

  fetch_skid_buf u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .skid      (skid.slave)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_BOOT;
      pc_f       <= RESET_PC;
      inf_pc     <= 32'h0;
      inf_vld    <= 1'b0;
      o_if_instr <= FETCH_NOP;
      o_if_pc    <= 32'h0;
      o_if_pc4   <= 32'h0;
      o_if_vld   <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_f    <= pc_nx;
      inf_pc  <= inf_pc_nx;
      inf_vld <= inf_vld_nx;
      if (ifid_load) begin
        o_if_instr <= ifid_instr_d;
        o_if_pc    <= ifid_pc_d;
        o_if_pc4   <= ifid_pc4_d;
        o_if_vld   <= ifid_vld_d;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    req             = 1'b0;
    flush           = 1'b0;
    pc_nx           = pc_f;
    inf_pc_nx       = inf_pc;
    inf_vld_nx      = inf_vld;
    ifid_load       = 1'b0;
    ifid_instr_d    = FETCH_NOP;
    ifid_pc_d       = 32'h0;
    ifid_pc4_d      = 32'h0;
    ifid_vld_d      = 1'b0;
    skid.load       = 1'b0;
    skid.clear      = 1'b0;
    skid.load_instr = i_imem_rdata;
    skid.load_pc    = inf_pc;

    case (state)
      S_BOOT: begin
        state_nx = S_RUN;
        if (i_redirect) pc_nx = align_pc(i_redirect_pc);
      end
      S_RUN: begin
        if (i_redirect) begin
          flush = 1'b1;
        end else if (!i_stall) begin
          req          = 1'b1;
          pc_nx        = pc_f + 32'd4;
          inf_pc_nx    = pc_f;
          inf_vld_nx   = 1'b1;
          ifid_load    = 1'b1;
          // A fetch slot with nothing in flight becomes a NOP bubble, never stale data.
          ifid_instr_d = inf_vld ? i_imem_rdata : FETCH_NOP;
          ifid_pc_d    = inf_pc;
          ifid_pc4_d   = inf_pc + 32'd4;
          ifid_vld_d   = inf_vld;
        end else begin
          inf_vld_nx = 1'b0;
          if (inf_vld) begin
            skid.load = 1'b1;
            state_nx  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          flush = 1'b1;
        end else if (!i_stall) begin
          req          = 1'b1;
          pc_nx        = pc_f + 32'd4;
          inf_pc_nx    = pc_f;
          inf_vld_nx   = 1'b1;
          ifid_load    = 1'b1;
          ifid_instr_d = skid.instr;
          ifid_pc_d    = skid.pc;
          ifid_pc4_d   = skid.pc + 32'd4;
          ifid_vld_d   = 1'b1;
          skid.clear   = 1'b1;
          state_nx     = S_RUN;
        end
      end
      default: state_nx = S_BOOT;
    endcase

    // Redirect overrides stall: drop everything in flight and present a bubble.
    if (flush) begin
      pc_nx        = align_pc(i_redirect_pc);
      inf_vld_nx   = 1'b0;
      skid.clear   = 1'b1;
      skid.load    = 1'b0;
      ifid_load    = 1'b1;
      ifid_instr_d = FETCH_NOP;
      ifid_pc_d    = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_vld_d   = 1'b0;
      state_nx     = S_RUN;
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = pc_f;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_perf_fetch    <= 32'h0;
      o_perf_redirect <= 32'h0;
    end else begin
      if (ifid_load && ifid_vld_d) o_perf_fetch <= o_perf_fetch + 32'd1;
      if (flush) o_perf_redirect <= o_perf_redirect + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid, redirects, misalignment, wrap.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr, if_pc, if_pc4;
  logic        if_vld;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_redirect;
`endif

  int checks;
  int failures;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .o_if_instr    (if_instr),
    .o_if_pc       (if_pc),
    .o_if_pc4      (if_pc4),
    .o_if_vld      (if_vld)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_fetch    (perf_fetch),
    .o_perf_redirect (perf_redirect)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory whose content is a signature of its address.
  always @(posedge clk) imem_rdata <= imem_addr ^ 32'hA5A5_0000;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] pc, input logic vld);
    checkOutput({tag, ".vld"}, {31'h0, if_vld}, {31'h0, vld});
    if (vld) begin
      checkOutput({tag, ".pc"}, if_pc, pc);
      checkOutput({tag, ".pc4"}, if_pc4, pc + 32'd4);
      checkOutput({tag, ".instr"}, if_instr, pc ^ 32'hA5A5_0000);
    end else begin
      checkOutput({tag, ".instr"}, if_instr, FETCH_NOP);
    end
  endtask

  task automatic checkFetch(input string tag, input logic req, input logic [31:0] addr);
    checkOutput({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
    checkOutput({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rdata  = 32'h0;

    repeat (3) tick();
    checkIfid("reset", 32'h0, 1'b0);
    checkOutput("reset.pc", if_pc, 32'h0);
    checkOutput("reset.pc4", if_pc4, 32'h0);
    checkFetch("reset", 1'b0, 32'h0);

    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    checkFetch("boot", 1'b0, 32'h0);
    tick(); checkFetch("c1", 1'b1, 32'h0);
    tick(); checkFetch("c2", 1'b1, 32'h4); checkIfid("c2", 32'h0, 1'b0);
    tick(); checkFetch("c3", 1'b1, 32'h8); checkIfid("c3", 32'h0, 1'b1);
    tick(); checkFetch("c4", 1'b1, 32'hC); checkIfid("c4", 32'h4, 1'b1);
    tick(); checkIfid("c5", 32'h8, 1'b1);

    // Three stalled edges while IF/ID holds PC 8.
    applyStimulus(1, 0, 0);
    checkFetch("stall0", 1'b0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIfid($sformatf("stall%0d", i + 1), 32'h8, 1'b1);
      if (i < 2) checkFetch($sformatf("stall%0d", i + 1), 1'b0, 32'h10);
    end
    applyStimulus(0, 0, 0);
    checkFetch("release", 1'b1, 32'h10);
    tick(); checkIfid("skid", 32'hC, 1'b1); checkFetch("skid", 1'b1, 32'h14);
    tick(); checkIfid("after_skid", 32'h10, 1'b1);

    // Redirect while running.
    applyStimulus(0, 1, 32'h100);
    checkFetch("redir", 1'b0, 32'h18);
    tick(); applyStimulus(0, 0, 0);
    checkIfid("redir_b1", 32'h0, 1'b0); checkFetch("redir_t", 1'b1, 32'h100);
    tick(); checkIfid("redir_b2", 32'h0, 1'b0);
    tick(); checkIfid("redir_t0", 32'h100, 1'b1);
    tick(); checkIfid("redir_t1", 32'h104, 1'b1);

    // Enter S_HOLD, then redirect and stall together.
    applyStimulus(1, 0, 0);
    tick(); checkIfid("hold", 32'h104, 1'b1);
    applyStimulus(1, 1, 32'h300);
    checkFetch("hold_redir", 1'b0, 32'h10C);
    tick(); applyStimulus(1, 0, 0);
    checkIfid("hr_b1", 32'h0, 1'b0); checkFetch("hr_stall", 1'b0, 32'h300);
    tick(); checkIfid("hr_b1h", 32'h0, 1'b0);
    applyStimulus(0, 0, 0);
    checkFetch("hr_go", 1'b1, 32'h300);
    tick(); checkIfid("hr_b2", 32'h0, 1'b0);
    tick(); checkIfid("hr_t", 32'h300, 1'b1);

    // Misaligned redirect target.
    applyStimulus(0, 1, 32'h203);
    tick(); applyStimulus(0, 0, 0);
    checkFetch("mis", 1'b1, 32'h200); checkIfid("mis_b1", 32'h0, 1'b0);
    tick(); checkIfid("mis_b2", 32'h0, 1'b0);
    tick(); checkIfid("mis_t", 32'h200, 1'b1);

    // Asynchronous reset while in S_HOLD.
    applyStimulus(1, 0, 0);
    tick(); checkIfid("pre_rst", 32'h200, 1'b1);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    checkIfid("async_rst", 32'h0, 1'b0);
    checkOutput("async_rst.pc", if_pc, 32'h0);
    checkOutput("async_rst.pc4", if_pc4, 32'h0);
    checkFetch("async_rst", 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    checkFetch("reboot", 1'b0, 32'h0);
    tick(); checkFetch("refetch", 1'b1, 32'h0);

    // PC wrap at the top of the address space.
    applyStimulus(0, 1, 32'hFFFF_FFFC);
    tick(); applyStimulus(0, 0, 0);
    checkFetch("wrap_top", 1'b1, 32'hFFFF_FFFC);
    tick(); checkFetch("wrap_zero", 1'b1, 32'h0);
    tick();
    checkOutput("wrap.pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap.pc4", if_pc4, 32'h0);
    checkOutput("wrap.instr", if_instr, 32'h5A5A_FFFC);
    checkOutput("wrap.vld", {31'h0, if_vld}, 32'h1);

`ifdef FETCH_PERF_CNT_EN
    // Since the last reset: one valid delivery (0xFFFFFFFC) and one accepted redirect.
    checkOutput("perf_fetch", perf_fetch, 32'd1);
    checkOutput("perf_redirect", perf_redirect, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
